// File: rtl/postage_deadlock_monitor_param.sv
// Deadlock monitor for an HLS dataflow region: persistence-filtered blocked flags,
// live per-channel info, and an optional sticky first-deadlock snapshot with event count.

module postage_deadlock_persist #(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sig,
  output logic q
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n)                          cnt <= '0;
    else if (!sig)                         cnt <= '0;
    else if (cnt != CNT_W'(HOLD_CYCLES))   cnt <= cnt + CNT_W'(1);
  end

  assign q = (cnt == CNT_W'(HOLD_CYCLES));
endmodule

module postage_deadlock_monitor_param #(
  parameter int NUM_AXIS    = 10,
  parameter int NUM_INST    = 1,
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1),
  parameter int IDX_W       = $clog2(NUM_AXIS + 1),
  parameter int EVT_W       = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_AXIS-1:0]          axis_block_sigs,
  input  logic [NUM_INST-1:0]          inst_idle_sigs,
  input  logic [NUM_INST-1:0]          inst_block_sigs,
  input  logic                         sticky_en,
  input  logic                         clear,
  output logic [NUM_AXIS*NUM_AXIS-1:0] axis_block_info,
  output logic                         block,
  output logic [IDX_W-1:0]             first_idx,
  output logic                         first_valid,
  output logic [EVT_W-1:0]             event_count
);
  localparam int INFO_W = NUM_AXIS * NUM_AXIS;

  logic [NUM_AXIS-1:0] q;
  logic [INFO_W-1:0]   live_info, snapshot;
  logic                raw_sub, sub_q, blk_live, blk_live_d, blk_sticky, rise;
  logic [IDX_W-1:0]    lowest;

  for (genvar i = 0; i < NUM_AXIS; i++) begin : g_ch
    localparam logic [NUM_AXIS-1:0] MASK = ~(NUM_AXIS'(1) << i);
    postage_deadlock_persist #(.HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)) u_persist (
      .clock   (clock),
      .reset_n (reset_n),
      .sig     (axis_block_sigs[i]),
      .q       (q[i])
    );
    assign live_info[i*NUM_AXIS +: NUM_AXIS] = q[i] ? MASK : '0;
  end

  // Region is stuck only if every instance is quiescent and at least one is blocked.
  assign raw_sub = (&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs);

  postage_deadlock_persist #(.HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)) u_sub_persist (
    .clock   (clock),
    .reset_n (reset_n),
    .sig     (raw_sub),
    .q       (sub_q)
  );

  assign blk_live = (|q) | sub_q;
  assign rise     = blk_live & ~blk_live_d;

  // Lowest qualifying channel; NUM_AXIS stands for the sub-instance term.
  always_comb begin
    lowest = IDX_W'(NUM_AXIS);
    for (int i = NUM_AXIS - 1; i >= 0; i--)
      if (q[i]) lowest = IDX_W'(i);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      blk_live_d  <= 1'b0;
      blk_sticky  <= 1'b0;
      snapshot    <= '0;
      first_idx   <= '0;
      first_valid <= 1'b0;
      event_count <= '0;
    end else begin
      blk_live_d <= blk_live;
      if (clear) begin
        blk_sticky  <= 1'b0;
        snapshot    <= '0;
        first_idx   <= '0;
        first_valid <= 1'b0;
        event_count <= '0;
      end else begin
        if (!blk_sticky && blk_live) begin
          blk_sticky  <= 1'b1;
          snapshot    <= live_info;
          first_idx   <= lowest;
          first_valid <= 1'b1;
        end
        if (rise && event_count != '1) event_count <= event_count + EVT_W'(1);
      end
    end
  end

  assign block           = sticky_en ? blk_sticky : blk_live;
  assign axis_block_info = sticky_en ? snapshot   : live_info;
endmodule

// File: tb/tb_postage_deadlock_monitor_param.sv
// Directed scoreboard bench: stimulus queues expected outputs per cycle, a monitor compares.

module tb_postage_deadlock_monitor_param;
  localparam int N  = 10;
  localparam int NI = 2;
  localparam int IW = 4;
  localparam int EW = 4;

  localparam logic [99:0] F1 = 100'h3FD << 10;
  localparam logic [99:0] F2 = 100'h3FB << 20;
  localparam logic [99:0] F3 = 100'h3F7 << 30;
  localparam logic [99:0] F5 = 100'h3DF << 50;
  localparam logic [99:0] F7 = 100'h37F << 70;

  logic          clock, reset_n, sticky_en, clear;
  logic [N-1:0]  axis;
  logic [NI-1:0] idle, iblk;
  logic [99:0]   info;
  logic          block, first_valid;
  logic [IW-1:0] first_idx;
  logic [EW-1:0] event_count;

  postage_deadlock_monitor_param #(
    .NUM_AXIS(N), .NUM_INST(NI), .HOLD_CYCLES(4), .EVT_W(EW)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .axis_block_sigs (axis),
    .inst_idle_sigs  (idle),
    .inst_block_sigs (iblk),
    .sticky_en       (sticky_en),
    .clear           (clear),
    .axis_block_info (info),
    .block           (block),
    .first_idx       (first_idx),
    .first_valid     (first_valid),
    .event_count     (event_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string         nm;
    bit            cb; logic eb;
    bit            ci; logic [99:0] ei;
    bit            cf; logic [IW-1:0] efi; logic efv;
    bit            ce; logic [EW-1:0] ee;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: every cycle the DUT presents one output set; compare against the head entry.
  always @(posedge clock) begin
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.cb) begin
        n_tests++;
        if (block !== e.eb) begin
          n_fail++; $display("FAIL %s block: got %b want %b", e.nm, block, e.eb);
        end
      end
      if (e.ci) begin
        n_tests++;
        if (info !== e.ei) begin
          n_fail++; $display("FAIL %s info: got %h want %h", e.nm, info, e.ei);
        end
      end
      if (e.cf) begin
        n_tests++;
        if (first_idx !== e.efi || first_valid !== e.efv) begin
          n_fail++;
          $display("FAIL %s first: got idx %0d valid %b want idx %0d valid %b",
                   e.nm, first_idx, first_valid, e.efi, e.efv);
        end
      end
      if (e.ce) begin
        n_tests++;
        if (event_count !== e.ee) begin
          n_fail++; $display("FAIL %s event_count: got %0d want %0d", e.nm, event_count, e.ee);
        end
      end
    end
  end

  task automatic step(input string nm, input bit cb, input logic eb, input bit ci,
                      input logic [99:0] ei, input bit cf, input logic [IW-1:0] efi,
                      input logic efv, input bit ce, input logic [EW-1:0] ee);
    exp_t x;
    x.nm = nm; x.cb = cb; x.eb = eb; x.ci = ci; x.ei = ei;
    x.cf = cf; x.efi = efi; x.efv = efv; x.ce = ce; x.ee = ee;
    exp_q.push_back(x);
    @(negedge clock);
  endtask

  task automatic nop(input int n);
    repeat (n) step("nop", 0, 0, 0, '0, 0, '0, 0, 0, '0);
  endtask

  task automatic zero(input string nm);
    step(nm, 1, 0, 1, '0, 1, '0, 0, 1, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 0; axis = '0; idle = '0; iblk = '0; sticky_en = 0; clear = 0;
    @(negedge clock);

    repeat (3) zero("reset");
    reset_n = 1;
    repeat (20) zero("idle");

    // Persistence filter, live mode
    axis = 10'b00_0000_1000;
    repeat (3) step("short_pulse", 1, 0, 1, '0, 0, '0, 0, 0, '0);
    axis = '0;
    step("short_gap", 1, 0, 1, '0, 0, '0, 0, 0, '0);
    axis = 10'b00_0000_1000;
    repeat (3) step("hold", 1, 0, 1, '0, 0, '0, 0, 0, '0);
    step("live_q4", 1, 1, 1, F3, 1, '0, 0, 1, '0);
    step("live_q5", 1, 1, 1, F3, 1, 4'd3, 1, 1, 4'd1);
    step("live_q6", 1, 1, 1, F3, 1, 4'd3, 1, 1, 4'd1);
    axis = '0;
    step("live_fall", 1, 0, 1, '0, 1, 4'd3, 1, 1, 4'd1);
    clear = 1;
    step("clr_live", 1, 0, 1, '0, 1, '0, 0, 1, '0);
    clear = 0;

    // Sticky capture, two channels qualifying together
    sticky_en = 1;
    axis = 10'b00_0010_0100;
    repeat (4) step("pre_sticky", 1, 0, 1, '0, 1, '0, 0, 1, '0);
    step("sticky_cap", 1, 1, 1, F2 | F5, 1, 4'd2, 1, 1, 4'd1);
    axis = '0;
    repeat (2) step("sticky_hold", 1, 1, 1, F2 | F5, 1, 4'd2, 1, 1, 4'd1);
    sticky_en = 0;
    step("live_view", 1, 0, 1, '0, 1, 4'd2, 1, 1, 4'd1);
    sticky_en = 1;
    step("sticky_view", 1, 1, 1, F2 | F5, 1, 4'd2, 1, 1, 4'd1);
    clear = 1;
    step("clr_sticky", 1, 0, 1, '0, 1, '0, 0, 1, '0);
    clear = 0;

    // Sub-instance term
    idle = 2'b01; iblk = 2'b10;
    repeat (4) step("sub_pre", 1, 0, 1, '0, 1, '0, 0, 1, '0);
    step("sub_cap", 1, 1, 1, '0, 1, 4'd10, 1, 1, 4'd1);
    idle = 2'b00;
    step("sub_hold", 1, 1, 1, '0, 1, 4'd10, 1, 1, 4'd1);
    clear = 1;
    step("sub_clr", 1, 0, 1, '0, 1, '0, 0, 1, '0);
    clear = 0;
    repeat (6) step("sub_busy", 1, 0, 1, '0, 1, '0, 0, 1, '0);
    iblk = '0;

    // Event saturation, live mode
    sticky_en = 0;
    for (int p = 0; p < 20; p++) begin
      axis = 10'b00_0000_0001;
      nop(4);
      axis = '0;
      step("evt_sat", 0, 0, 0, '0, 0, '0, 0, 1, (p + 1 > 15) ? 4'd15 : 4'(p + 1));
    end
    step("evt_final", 1, 0, 1, '0, 0, '0, 0, 1, 4'd15);
    clear = 1;
    step("evt_clr", 1, 0, 1, '0, 1, '0, 0, 1, '0);
    clear = 0;
    axis = 10'b00_0000_0001;
    nop(4);
    axis = '0; clear = 1;
    step("clr_prio", 0, 0, 0, '0, 1, '0, 0, 1, '0);
    clear = 0;
    step("clr_prio_after", 1, 0, 1, '0, 1, '0, 0, 1, '0);

    // Reset mid-operation
    sticky_en = 1;
    axis = 10'b00_1000_0000;
    nop(3);
    axis = 10'b00_1000_0010;
    step("rst_pre_live", 1, 0, 1, '0, 1, '0, 0, 1, '0);
    step("rst_pre_stk", 1, 1, 1, F7, 1, 4'd7, 1, 1, 4'd1);
    reset_n = 0;
    zero("mid_reset");
    reset_n = 1; sticky_en = 0;
    repeat (3) step("requal_wait", 1, 0, 1, '0, 1, '0, 0, 1, '0);
    step("requal", 1, 1, 1, F1 | F7, 1, '0, 0, 1, '0);
    sticky_en = 1;
    step("requal_stk", 1, 1, 1, F1 | F7, 1, 4'd1, 1, 1, 4'd1);
    axis = '0;

    repeat (3) @(negedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/postage_deadlock_monitor_param.md
# postage_deadlock_monitor_param

Parametrised deadlock monitor for an HLS dataflow region in the postage pipeline. It watches NUM_AXIS stream-blocked flags plus a group of sub-instance idle/block flags. A channel is flagged only after its blocked flag has stayed high for HOLD_CYCLES consecutive cycles, which filters transient back-pressure. It reports live per-channel block info, and in sticky mode it also latches the first deadlock snapshot, the first offending channel, and a count of block events until software clears them.

## Interface
Parameters:
- NUM_AXIS, 10: number of monitored AXIS blocked flags, 1..64.
- NUM_INST, 1: number of sub-instance idle/block flag pairs, ≥1.
- HOLD_CYCLES, 1: consecutive blocked cycles before a flag qualifies, ≥1.
- CNT_W, clog2(HOLD_CYCLES+1): width of the persistence counters (derived).
- IDX_W, clog2(NUM_AXIS+1): width of first_idx (derived).
- EVT_W, 16: width of event_count.

Ports:
- clock, in, 1: sole clock; all logic on the rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- axis_block_sigs, in, NUM_AXIS: bit i high = stream i blocked this cycle.
- inst_idle_sigs, in, NUM_INST: sub-instance idle flags.
- inst_block_sigs, in, NUM_INST: sub-instance blocked flags.
- sticky_en, in, 1: 0 = live mode, 1 = sticky mode.
- clear, in, 1: one-cycle pulse; clears the sticky state.
- axis_block_info, out, NUM_AXIS*NUM_AXIS: per-channel info fields.
- block, out, 1: deadlock indication.
- first_idx, out, IDX_W: first qualifying channel; value NUM_AXIS = sub-instance term.
- first_valid, out, 1: first_idx is meaningful.
- event_count, out, EVT_W: number of rising edges of the live block, saturating.

## Operation
- Channel counters cnt[i], one per AXIS channel:
  - If axis_block_sigs[i] is high, cnt[i] increments, saturating at HOLD_CYCLES.
  - Otherwise cnt[i] returns to 0.
  - q[i] = (cnt[i] == HOLD_CYCLES).
- Sub-instance term:
  - raw_sub = AND over j of (inst_block_sigs[j] | inst_idle_sigs[j]), and OR over j of inst_block_sigs[j]. That is: every instance is idle or blocked, and at least one is blocked.
  - raw_sub feeds its own counter with the same rule as the channel counters; it qualifies as sub_q.
- Live outputs, decoded from the counter registers:
  - blk_live = (OR of q) | sub_q.
  - Info field i occupies bits [i*NUM_AXIS +: NUM_AXIS] and equals q[i] ? ~(1<<i) : 0.
- Sticky state, updated every cycle regardless of sticky_en:
  - While blk_sticky is 0 and blk_live is 1:
    - Set blk_sticky.
    - Snapshot the live info vector.
    - first_idx = lowest i with q[i] set, else NUM_AXIS if only sub_q is set.
    - first_valid = 1.
  - While blk_sticky is 1, the snapshot, first_idx and first_valid are frozen.
  - event_count increments on each 0→1 transition of blk_live and saturates at all-ones.
  - clear zeroes blk_sticky, the snapshot, first_idx, first_valid and event_count. Clear has priority over set and increment in the same cycle.
  - If the block condition persists after a clear, the sticky state re-arms on the next cycle. No edge is counted, because blk_live did not rise.
  - clear does not touch the persistence counters.
- Output selection:
  - block = sticky_en ? blk_sticky : blk_live.
  - axis_block_info = sticky_en ? snapshot : live info.
  - first_idx, first_valid and event_count are always driven from the sticky registers.
- Changing sticky_en takes effect combinationally on the outputs. No state is altered by it.

## Timing
- Reset: all counters, blk_sticky, snapshot, first_idx, first_valid and event_count are 0. Hence block = 0, axis_block_info = 0, first_idx = 0, first_valid = 0, event_count = 0.
- Live latency: axis_block_sigs[i] high continuously from cycle t gives q[i] and live block = 1 at cycle t+HOLD_CYCLES.
  - With HOLD_CYCLES = 1 this is a plain one-cycle registered monitor.
- Live deassertion: one cycle after the input falls.
- Sticky latency: blk_sticky, the snapshot and first_idx appear one cycle after blk_live, i.e. at t+HOLD_CYCLES+1.
- A gap of one low cycle restarts the count from 0.
- Simultaneous qualification of several channels in the same cycle: the lowest index wins first_idx. The snapshot contains all of them.
- reset_n low mid-count or mid-sticky returns everything to reset values on that edge. reset_n has priority over clear.

## Test plan
- Reset and idle: hold reset_n = 0 for 3 cycles, then all inputs 0 for 20 cycles. Required: block = 0, axis_block_info = 0, event_count = 0 throughout.
- Persistence with HOLD_CYCLES = 4 and sticky_en = 0:
  - axis_block_sigs[3] high for 3 cycles, then low: block stays 0.
  - Then high for 6 cycles from cycle t: block = 1 from t+4 to t+6, field 3 = 10'h3F7, and block returns to 0 at t+7.
- Sticky capture with sticky_en = 1:
  - Channels 5 and 2 qualify in the same cycle: first_idx = 2, first_valid = 1, and the snapshot holds fields 2 and 5.
  - Both inputs drop: block stays 1 and event_count = 1.
  - Pulse clear: all sticky outputs read 0 the next cycle.
- Sub-instance term with NUM_INST = 2:
  - idle = 2'b01, block = 2'b10: sub_q qualifies and first_idx = NUM_AXIS.
  - idle = 2'b00, block = 2'b10: never flagged.
- Event saturation and clear priority with EVT_W = 4:
  - 20 separated block pulses leave event_count at 15.
  - clear asserted in the same cycle as a new rising edge: event_count reads 0.
- Reset mid-operation: with the sticky state set and counters mid-way, drive reset_n = 0 for one cycle. Required: all outputs 0 on the next cycle, and re-qualification takes the full HOLD_CYCLES again.
